// File: rtl/stage_4_mem_pkg.sv
// stage_4_mem_pkg: shared load-type codes, bus widths and FSM states for the MEM stage.
package stage_4_mem_pkg;

    localparam int IN_W  = 73;
    localparam int OUT_W = 70;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_B    = 3'd1;
    localparam logic [2:0] LD_BU   = 3'd2;
    localparam logic [2:0] LD_H    = 3'd3;
    localparam logic [2:0] LD_HU   = 3'd4;
    localparam logic [2:0] LD_W    = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Codes 6 and 7 are reserved and behave like a non-load.
    function automatic logic is_load(input logic [2:0] ld_type);
        return (ld_type != LD_NONE) && (ld_type <= LD_W);
    endfunction

endpackage

// File: rtl/stage_4_mem_load_ext.sv
// stage_4_mem_load_ext: selects the addressed byte/half of a read word and sign/zero extends it.
module stage_4_mem_load_ext
    import stage_4_mem_pkg::*;
(
    input  logic [2:0]  i_ld_type,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rd,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = i_rd[{i_addr_lo, 3'b000} +: 8];
        w_half   = i_addr_lo[1] ? i_rd[31:16] : i_rd[15:0];
        o_result = (i_ld_type == LD_B)  ? {{24{w_byte[7]}}, w_byte} :
                   (i_ld_type == LD_BU) ? {24'd0, w_byte} :
                   (i_ld_type == LD_H)  ? {{16{w_half[15]}}, w_half} :
                   (i_ld_type == LD_HU) ? {16'd0, w_half} :
                   i_rd;
    end

endmodule

// File: rtl/stage_4_mem.sv
// stage_4_mem: MEM pipeline stage; latches EX results, waits for load data, buffers it under
// WB backpressure and drives the WB bus plus the forwarding/stall bus back to ID.
module stage_4_mem
    import stage_4_mem_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid_3,
    output logic             o_allow_4,
    input  logic [IN_W-1:0]  i_stage_3_to_4,
    input  logic             i_data_sram_data_ok,
    input  logic [31:0]      i_data_sram_rdata,
    output logic             o_valid_4,
    input  logic             i_allow_5,
    output logic [OUT_W-1:0] o_stage_4_to_5,
    output logic             o_fwd_4_we,
    output logic [4:0]       o_fwd_4_dest,
    output logic [31:0]      o_fwd_4_data,
    output logic             o_fwd_4_stall
);

    logic            r_v4;
    logic [IN_W-1:0] r_bus;
    logic            r_buf_valid;
    logic [31:0]     r_data_buf;
    state_t          r_state;
    state_t          w_state_next;

    logic [2:0]  w_ld_type;
    logic        w_rf_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu;
    logic [31:0] w_pc;
    logic [31:0] w_rd;
    logic [31:0] w_ext;
    logic [31:0] w_final;
    logic        w_is_load;
    logic        w_data_ok;
    logic        w_readygo;
    logic        w_load_in;
    logic        w_capture;

    assign {w_ld_type, w_rf_we, w_dest, w_alu, w_pc} = r_bus;

    // A response only counts while a latched load is actually waiting for it.
    assign w_is_load = is_load(w_ld_type);
    assign w_data_ok = i_data_sram_data_ok & (r_state == S_WAIT);
    assign w_readygo = ~w_is_load | w_data_ok | r_buf_valid;
    assign o_allow_4 = ~r_v4 | (w_readygo & i_allow_5);
    assign o_valid_4 = r_v4 & w_readygo;
    assign w_load_in = i_valid_3 & o_allow_4 & is_load(i_stage_3_to_4[IN_W-1 -: 3]);
    assign w_capture = w_data_ok & ~i_allow_5;
    assign w_rd      = r_buf_valid ? r_data_buf : i_data_sram_rdata;

    stage_4_mem_load_ext u_load_ext (
        .i_ld_type (w_ld_type),
        .i_addr_lo (w_alu[1:0]),
        .i_rd      (w_rd),
        .o_result  (w_ext)
    );

    assign w_final        = w_is_load ? w_ext : w_alu;
    assign o_stage_4_to_5 = {w_rf_we & r_v4, w_dest, w_final, w_pc};
    assign o_fwd_4_we     = r_v4 & w_rf_we & (w_dest != 5'd0);
    assign o_fwd_4_stall  = o_fwd_4_we & w_is_load & ~w_readygo;
    assign o_fwd_4_dest   = w_dest;
    assign o_fwd_4_data   = w_final;

    // Whenever the stage advances, the next state depends only on whether a load enters.
    always_comb begin
        w_state_next = r_state;
        w_state_next = o_allow_4 ? (w_load_in ? S_WAIT : S_IDLE) :
                       w_capture ? S_HOLD : r_state;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_v4        <= 1'b0;
            r_bus       <= '0;
            r_buf_valid <= 1'b0;
            r_data_buf  <= '0;
            r_state     <= S_IDLE;
        end else begin
            r_state <= w_state_next;
            if (o_allow_4)
                r_v4 <= i_valid_3;
            if (i_valid_3 & o_allow_4)
                r_bus <= i_stage_3_to_4;
            if (w_capture) begin
                r_buf_valid <= 1'b1;
                r_data_buf  <= i_data_sram_rdata;
            end else if ((r_state == S_HOLD) & i_allow_5) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

endmodule
